wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_stage : one-entry writeback pipeline register selecting RF/CSR data.  |
// | Optional retire counter under macro WB_STAGE_RETIRE_CNT_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int CSR_WEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      in_ex_result,
    input  logic [XLEN-1:0]      in_mem_rdata,
    input  logic [XLEN-1:0]      in_csrs,
    input  logic [REG_AW-1:0]    in_rd,
    input  logic [CSR_WEN_W-1:0] in_csr_wen,
    input  logic                 in_r_wen,
    input  logic                 in_mem_ren,
    input  logic                 in_jump,
    input  logic                 in_branch,
    input  logic                 flush,
    input  logic                 wb_ready,
    output logic                 out_valid,
    output logic                 rf_wen,
    output logic [REG_AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [CSR_WEN_W-1:0] csr_wen,
    output logic [XLEN-1:0]      csr_wdata,
    output logic                 branch_out,
    output logic [XLEN-1:0]      retire_pc
`ifdef WB_STAGE_RETIRE_CNT_EN
    ,
    output logic [63:0]          retire_cnt
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic                 valid_q;
    logic [XLEN-1:0]      pc_q;
    logic [XLEN-1:0]      ex_result_q;
    logic [XLEN-1:0]      mem_rdata_q;
    logic [XLEN-1:0]      csrs_q;
    logic [REG_AW-1:0]    rd_q;
    logic [CSR_WEN_W-1:0] csr_wen_q;
    logic                 r_wen_q;
    logic                 mem_ren_q;
    logic                 jump_q;
    logic                 branch_q;

    logic accept;
    logic commit;

    assign in_ready = !valid_q || wb_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign commit   = valid_q && wb_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            ex_result_q <= '0;
            mem_rdata_q <= '0;
            csrs_q      <= '0;
            rd_q        <= '0;
            csr_wen_q   <= '0;
            r_wen_q     <= 1'b0;
            mem_ren_q   <= 1'b0;
            jump_q      <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            // flush dominates; a drained slot empties only when nothing replaces it
            if (flush)         valid_q <= 1'b0;
            else if (accept)   valid_q <= 1'b1;
            else if (wb_ready) valid_q <= 1'b0;

            if (accept) begin
                pc_q        <= in_pc;
                ex_result_q <= in_ex_result;
                mem_rdata_q <= in_mem_rdata;
                csrs_q      <= in_csrs;
                rd_q        <= in_rd;
                csr_wen_q   <= in_csr_wen;
                r_wen_q     <= in_r_wen;
                mem_ren_q   <= in_mem_ren;
                jump_q      <= in_jump;
                branch_q    <= in_branch;
            end
        end
    end

    always_comb begin
        rf_wdata = ex_result_q;
        if (jump_q)               rf_wdata = pc_q + PC_STEP;
        else if (mem_ren_q)       rf_wdata = mem_rdata_q;
        else if (csr_wen_q != '0) rf_wdata = csrs_q;
    end

    assign out_valid  = valid_q;
    assign rf_wen     = commit && r_wen_q && (rd_q != '0);
    assign rf_waddr   = rd_q;
    assign csr_wen    = commit ? csr_wen_q : '0;
    assign csr_wdata  = ex_result_q;
    assign branch_out = commit && branch_q;
    assign retire_pc  = pc_q;

`ifdef WB_STAGE_RETIRE_CNT_EN
    logic [63:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (commit) cnt_q <= cnt_q + 64'd1;
    end

    assign retire_cnt = cnt_q;
`endif

endmodule
`default_nettype wire
